// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: applies every input vector to a netlist, captures and grades its outputs.
// Optional MISR signature over the captured outputs when SWEEP_MISR_EN is defined.
module tt_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [N_OUT*(2**N_IN)-1:0]   golden_i,
  output logic [N_IN-1:0]              dut_in_o,
  input  logic [N_OUT-1:0]             dut_out_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [N_OUT*(2**N_IN)-1:0]   tt_out_o,
  output logic [N_IN-1:0]              fail_idx_o,
  output logic [N_IN:0]                mismatch_cnt_o,
  output logic [15:0]                  signature_o
);

  localparam int NV    = 2**N_IN;
  localparam int TW    = N_OUT*NV;
  localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]     golden_q, golden_d;
  logic [TW-1:0]     tt_q, tt_d;
  logic [N_IN-1:0]   fail_idx_q, fail_idx_d;
  logic [N_IN:0]     mcnt_q, mcnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_OUT-1:0]  miss_vec;
  logic              miss;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_miss
      assign miss_vec[gi] = dut_out_i[gi] ^ golden_q[gi*NV + int'(idx_q)];
    end
  endgenerate
  assign miss = |miss_vec;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    golden_d   = golden_q;
    tt_d       = tt_q;
    fail_idx_d = fail_idx_q;
    mcnt_d     = mcnt_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          golden_d   = golden_i;
          tt_d       = '0;
          mcnt_d     = '0;
          fail_idx_d = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          cnt_d      = CNT_W'(SETTLE);
          state_d    = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        // An abort in this cycle drops the capture entirely.
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          for (int o = 0; o < N_OUT; o++) tt_d[o*NV + int'(idx_q)] = dut_out_i[o];
          if (miss) begin
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_q == '0) fail_idx_d = idx_q;
          end
          if (idx_q == {N_IN{1'b1}}) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = CNT_W'(SETTLE);
            state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        pass_d  = (mcnt_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      golden_q   <= '0;
      tt_q       <= '0;
      fail_idx_q <= '0;
      mcnt_q     <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      golden_q   <= golden_d;
      tt_q       <= tt_d;
      fail_idx_q <= fail_idx_d;
      mcnt_q     <= mcnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

`ifdef SWEEP_MISR_EN
  logic [15:0] sig_q, sig_d;
  logic        misr_seed, misr_step;

  assign misr_seed = (state_q == S_IDLE) && start_i;
  assign misr_step = (state_q == S_SAMPLE) && !abort_i;

  always_comb begin
    sig_d = sig_q;
    if (misr_seed) begin
      sig_d = 16'hFFFF;
    end else if (misr_step) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ 16'(dut_out_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 16'hFFFF;
    else     sig_q <= sig_d;
  end

  assign signature_o = sig_q;
`else
  assign signature_o = 16'hFFFF;
`endif

  assign dut_in_o       = idx_q;
  assign busy_o         = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign tt_out_o       = tt_q;
  assign fail_idx_o     = fail_idx_q;
  assign mismatch_cnt_o = mcnt_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: three builds (SETTLE=1,0,3) run in lockstep against a table-driven netlist model.
module tb_tt_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] golden;
  logic [31:0] net_tt;

  logic [3:0]  din   [3];
  logic [1:0]  dout  [3];
  logic        busy  [3];
  logic        done  [3];
  logic        pass  [3];
  logic [31:0] tt    [3];
  logic [3:0]  fidx  [3];
  logic [4:0]  mcnt  [3];
  logic [15:0] sig   [3];

  int sv [3] = '{1, 0, 3};
  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Netlist under test: output o at vector v is net_tt[o*16+v].
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_net
      assign dout[gi] = {net_tt[16 + din[gi]], net_tt[din[gi]]};
    end
  endgenerate

  tt_sweep_ctrl #(.N_IN(4), .N_OUT(2), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .golden_i(golden),
    .dut_in_o(din[0]), .dut_out_i(dout[0]), .busy_o(busy[0]), .done_o(done[0]),
    .pass_o(pass[0]), .tt_out_o(tt[0]), .fail_idx_o(fidx[0]),
    .mismatch_cnt_o(mcnt[0]), .signature_o(sig[0]));

  tt_sweep_ctrl #(.N_IN(4), .N_OUT(2), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .golden_i(golden),
    .dut_in_o(din[1]), .dut_out_i(dout[1]), .busy_o(busy[1]), .done_o(done[1]),
    .pass_o(pass[1]), .tt_out_o(tt[1]), .fail_idx_o(fidx[1]),
    .mismatch_cnt_o(mcnt[1]), .signature_o(sig[1]));

  tt_sweep_ctrl #(.N_IN(4), .N_OUT(2), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .golden_i(golden),
    .dut_in_o(din[2]), .dut_out_i(dout[2]), .busy_o(busy[2]), .done_o(done[2]),
    .pass_o(pass[2]), .tt_out_o(tt[2]), .fail_idx_o(fidx[2]),
    .mismatch_cnt_o(mcnt[2]), .signature_o(sig[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grades a whole sweep from the table rules: per-vector compare, first miss, count, MISR.
  function automatic void ref_model(input logic [31:0] net, input logic [31:0] gold,
                                    output logic [4:0] cnt, output logic [3:0] fi,
                                    output logic [15:0] s);
    logic [1:0] o;
    logic [1:0] g;
    cnt = 0;
    fi  = 0;
    s   = 16'hFFFF;
    for (int v = 0; v < 16; v++) begin
      o = {net[16 + v], net[v]};
      g = {gold[16 + v], gold[v]};
      if (o != g) begin
        if (cnt == 0) fi = v[3:0];
        cnt = cnt + 1;
      end
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, o};
    end
  endfunction

  function automatic logic [3:0] exp_vec(input int k, input int s);
    if (k < 16 * (s + 1)) return 4'(k / (s + 1));
    return 4'd15;
  endfunction

  function automatic logic [31:0] pmask(input int n);
    logic [31:0] m = 0;
    for (int v = 0; v < n; v++) begin
      m[v]      = 1'b1;
      m[v + 16] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [15:0] exp_sig(input logic [15:0] s);
`ifdef SWEEP_MISR_EN
    return s;
`else
    return 16'hFFFF + 16'(s & 16'h0);
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s_s%0d_ctl", tag, sv[j]), {din[j], busy[j], done[j], pass[j]}, 7'd0);
      chk($sformatf("%s_s%0d_res", tag, sv[j]), {tt[j], fidx[j], mcnt[j], sig[j]},
          {32'd0, 4'd0, 5'd0, 16'hFFFF});
    end
  endtask

  // Full sweep in all three builds; per-cycle check of busy/vector/done, results at done.
  task automatic sweep(input logic [31:0] gold, input logic [31:0] net, input int poke_k);
    logic [4:0]  ecnt;
    logic [3:0]  efi;
    logic [15:0] esig;
    int lat;
    net_tt = net;
    golden = gold;
    ref_model(net, gold, ecnt, efi, esig);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 66; k++) begin
      for (int j = 0; j < 3; j++) begin
        lat = 16 * (sv[j] + 1) + 1;
        chk($sformatf("seq_s%0d_k%0d", sv[j], k), {busy[j], din[j], done[j]},
            {k < lat - 1, exp_vec(k, sv[j]), k == lat});
        if (k == lat) begin
          chk($sformatf("tt_s%0d", sv[j]), tt[j], net);
          chk($sformatf("grade_s%0d", sv[j]), {pass[j], mcnt[j], fidx[j]},
              {ecnt == 0, ecnt, efi});
          chk($sformatf("sig_s%0d", sv[j]), sig[j], exp_sig(esig));
        end else if (k > lat) begin
          chk($sformatf("pass_hold_s%0d_k%0d", sv[j], k), pass[j], ecnt == 0);
        end
      end
      start = (k == poke_k);
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    $display("sweep gold=%08h net=%08h poke=%0d exp_cnt=%0d exp_fidx=%0d", gold, net, poke_k, ecnt, efi);
  endtask

  initial begin
    logic [31:0] nr;
    logic [31:0] gr;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    golden = 32'd0;
    net_tt = 32'hF000_6996;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    sweep(32'hF000_6996, 32'hF000_6996, -1);
    sweep(32'hF000_69B6, 32'hF000_6996, -1);
    sweep(32'hE000_69B6, 32'hF000_6996, -1);
    sweep(32'h0FFF_9669, 32'hF000_6996, -1);
    sweep(32'hF000_6996, 32'hF000_6996, 10);
    sweep(32'hF000_6996, 32'hF000_6996, -1);

    // Abort while the SETTLE=1 build drives vector 7.
    net_tt = 32'hF000_6996;
    golden = net_tt;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("abort_vec", din[0], 4'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("abort_ctl_s%0d", sv[j]), {busy[j], done[j], pass[j]}, 3'd0);
      chk($sformatf("abort_tt_s%0d", sv[j]), tt[j], net_tt & pmask(14 / (sv[j] + 1)));
    end
    for (int c = 0; c < 40; c++) begin
      for (int j = 0; j < 3; j++) chk($sformatf("abort_nodone_s%0d", sv[j]), done[j], 1'b0);
      @(negedge clk);
    end
    $display("abort at vector 7 done");
    sweep(32'hF000_6996, 32'hF000_6996, -1);

    // Asynchronous reset while the SETTLE=1 build drives vector 9.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk("rst_vec", din[0], 4'd9);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int j = 0; j < 3; j++) chk($sformatf("rst_idle_s%0d", sv[j]), {busy[j], done[j]}, 2'd0);
      @(negedge clk);
    end
    $display("reset at vector 9 done");

    for (int r = 0; r < 5; r++) begin
      nr = $urandom;
      gr = nr;
      repeat ($urandom_range(0, 3)) gr = gr ^ (32'd1 << $urandom_range(0, 31));
      sweep(gr, nr, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
